// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter (line-compatible with buart).
//
// A circular byte FIFO decouples the writer from the bit-rate serialiser.
// Frames are LSB first: start (0), 8 data bits, optional even parity, stop (1).
// Queued bytes go out back to back with no idle gap between frames.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> even-parity slot between data and stop (11-bit frame)
//   undefined -> plain 8N1, 10-bit frame (default build)
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (2..65535)
//   FIFO_DEPTH    FIFO entries, power of two (2..256)
// Ports:
//   clk      single clock, rising edge
//   resetq   asynchronous active-low reset
//   wr       write strobe; byte accepted when wr && !full
//   tx_data  byte sampled with wr
//   tx       serial output, idles high
//   full     FIFO holds FIFO_DEPTH bytes
//   empty    FIFO holds no bytes
//   busy     frame on the line or FIFO non-empty
//   level    FIFO occupancy
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          resetq,
    input  logic                          wr,
    input  logic [7:0]                    tx_data,
    output logic                          tx,
    output logic                          full,
    output logic                          empty,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    // FIFO storage and bookkeeping
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              r_full;
    logic              r_empty;
    logic              r_busy;
    logic              w_push;
    logic              w_pop;
    logic [7:0]        w_head;

    // Serialiser state
    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baud_nxt;
    logic [2:0]        r_bit_idx;
    logic [2:0]        w_bit_idx_nxt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nxt;
    logic              r_tx;
    logic              w_tx_nxt;
    logic              w_bit_end;
`ifdef UART_TX_PARITY_EN
    logic              r_parity;
    logic              w_parity_nxt;
`endif

    assign w_push    = wr & ~r_full;
    assign w_head    = r_mem[r_rptr];
    assign w_bit_end = (r_baud == BAUD_LAST);

    // Next-state, shift and line value; tx is registered from w_tx_nxt
    always_comb begin
        w_state_nxt   = r_state;
        w_baud_nxt    = w_bit_end ? '0 : r_baud + BAUD_W'(1);
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        w_pop         = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt  = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                w_tx_nxt   = 1'b1;
                if (!r_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt = ^w_head;
`endif
                    w_state_nxt = S_START;
                    w_tx_nxt    = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt   = S_DATA;
                    w_bit_idx_nxt = 3'd0;
                    w_tx_nxt      = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
                        w_tx_nxt    = r_parity;
`else
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        w_shift_nxt   = r_shift >> 1;
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_tx_nxt      = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    // Chain straight into the next start bit when data is waiting
                    if (!r_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
`ifdef UART_TX_PARITY_EN
                        w_parity_nxt = ^w_head;
`endif
                        w_state_nxt = S_START;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = '0;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    // Occupancy: simultaneous push and pop cancel out
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO storage; contents are don't-care after reset since pointers clear
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= tx_data;
        end
    end

    // State, pointers and registered flags
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            r_count   <= w_count_nxt;
            r_full    <= (w_count_nxt == CNT_FULL);
            r_empty   <= (w_count_nxt == '0);
            r_busy    <= (w_state_nxt != S_IDLE) | (w_count_nxt != '0);
`ifdef UART_TX_PARITY_EN
            r_parity  <= w_parity_nxt;
`endif
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
        end
    end

    assign tx    = r_tx;
    assign full  = r_full;
    assign empty = r_empty;
    assign busy  = r_busy;
    assign level = r_count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLKS_PER_BIT=4, FIFO_DEPTH=16.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_uart_tx_fifo;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       resetq = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx;
    logic       full;
    logic       empty;
    logic       busy;
    logic [4:0] level;

    int errors = 0;
    int checks = 0;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetq(resetq), .wr(wr), .tx_data(tx_data),
        .tx(tx), .full(full), .empty(empty), .busy(busy), .level(level)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Expected line value for frame slot j of byte d
    function automatic logic frame_bit(input logic [7:0] d, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return d[j-1];
`ifdef UART_TX_PARITY_EN
        if (j == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Bench-side receiver: waits for a start bit, samples bit centres
    task automatic rx_byte(output logic [7:0] b, output logic stop_bit, output logic found);
        found = 1'b0;
        b = 8'h00;
        stop_bit = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (tx === 1'b0) found = 1'b1;
            else tick();
        end
        if (found) begin
            repeat (2) tick();
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) tick();
                b[i] = tx;
            end
            repeat (CPB * (NBITS - 9)) tick();
            stop_bit = tx;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy !== 1'b0; i++) tick();
    endtask

    task automatic test_reset();
        resetq = 1'b0;
        wr = 1'b0;
        repeat (2) tick();
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        resetq = 1'b1;
        repeat (3) tick();
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: tx=%b busy=%b expected tx=1 busy=0", tx, busy); end
    endtask

    task automatic test_single();
        wr = 1'b1; tx_data = 8'h55;
        tick();
        wr = 1'b0;
        checks++; if (empty !== 1'b0 || level !== 5'd1) begin errors++; $display("FAIL single_queued: empty=%b level=%0d expected empty=0 level=1", empty, level); end
        checks++; if (tx !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_pre_start: tx=%b busy=%b expected tx=1 busy=1", tx, busy); end
        tick();
        checks++; if (empty !== 1'b1 || level !== 5'd0) begin errors++; $display("FAIL single_popped: empty=%b level=%0d expected empty=1 level=0", empty, level); end
        for (int k = 0; k < int'(NBITS * CPB); k++) begin
            checks++;
            if (tx !== frame_bit(8'h55, k / CPB)) begin
                errors++; $display("FAIL single_line cycle %0d: got %b expected %b", k, tx, frame_bit(8'h55, k / CPB));
            end
            if (k == int'(NBITS * CPB) - 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_last: got %b expected 1", busy); end
            end
            tick();
        end
        checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL single_done: busy=%b tx=%b expected busy=0 tx=1", busy, tx); end
    endtask

    task automatic test_back_to_back();
        logic line [0:2*NBITS*CPB-1];
        int dur;
        logic [7:0] d;
        wr = 1'b1; tx_data = 8'h41;
        tick();
        tx_data = 8'h42;
        tick();
        wr = 1'b0;
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL b2b_start: got %b expected 0", tx); end
        dur = 0;
        while (busy === 1'b1 && dur < 500) begin
            if (dur < int'(2 * NBITS * CPB)) line[dur] = tx;
            dur++;
            tick();
        end
        checks++; if (dur != int'(2 * NBITS * CPB)) begin errors++; $display("FAIL b2b_busy_len: got %0d expected %0d", dur, 2 * NBITS * CPB); end
        checks++; if (line[NBITS*CPB] !== 1'b0) begin errors++; $display("FAIL b2b_no_gap: got %b expected 0", line[NBITS*CPB]); end
        for (int s = 0; s < int'(2 * NBITS); s++) begin
            d = (s < int'(NBITS)) ? 8'h41 : 8'h42;
            checks++;
            if (line[s*CPB+2] !== frame_bit(d, s % NBITS)) begin
                errors++; $display("FAIL b2b_slot %0d: got %b expected %b", s, line[s*CPB+2], frame_bit(d, s % NBITS));
            end
        end
    endtask

    task automatic test_late_write();
        logic [7:0] b;
        logic sb, found;
        wr = 1'b1; tx_data = 8'h41;
        tick();
        wr = 1'b0;
        tick();
        repeat (NBITS * CPB - 1) tick();
        wr = 1'b1; tx_data = 8'h42;
        tick();
        wr = 1'b0;
        checks++; if (tx !== 1'b1 || level !== 5'd1) begin errors++; $display("FAIL late_idle_gap: tx=%b level=%0d expected tx=1 level=1", tx, level); end
        tick();
        checks++; if (tx !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL late_start: tx=%b level=%0d expected tx=0 level=0", tx, level); end
        rx_byte(b, sb, found);
        checks++; if (!found || b !== 8'h42 || sb !== 1'b1) begin errors++; $display("FAIL late_byte: got %h stop=%b expected 42 stop=1", b, sb); end
        wait_idle();
    endtask

    task automatic test_overflow();
        logic [7:0] got [17];
        logic       sb [17];
        logic       fnd [17];
        int maxlvl;
        maxlvl = 0;
        fork
            begin
                for (int i = 0; i < 17; i++) begin
                    wr = 1'b1; tx_data = 8'(i);
                    tick();
                    if (int'(level) > maxlvl) maxlvl = int'(level);
                end
                checks++; if (full !== 1'b1 || level !== 5'd16) begin errors++; $display("FAIL ovf_full: full=%b level=%0d expected full=1 level=16", full, level); end
                tx_data = 8'hEE;
                tick();
                wr = 1'b0;
                if (int'(level) > maxlvl) maxlvl = int'(level);
                checks++; if (full !== 1'b1 || level !== 5'd16) begin errors++; $display("FAIL ovf_drop: full=%b level=%0d expected full=1 level=16", full, level); end
                checks++; if (maxlvl != 16) begin errors++; $display("FAIL ovf_max_level: got %0d expected 16", maxlvl); end
            end
            begin
                for (int i = 0; i < 17; i++) rx_byte(got[i], sb[i], fnd[i]);
            end
        join
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (!fnd[i] || got[i] !== 8'(i) || sb[i] !== 1'b1) begin
                errors++; $display("FAIL ovf_rx %0d: got %h stop=%b expected %h stop=1", i, got[i], sb[i], 8'(i));
            end
        end
        repeat (3) tick();
        checks++; if (busy !== 1'b0 || empty !== 1'b1 || tx !== 1'b1) begin errors++; $display("FAIL ovf_drained: busy=%b empty=%b tx=%b expected 0 1 1", busy, empty, tx); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        logic sb, found, saw;
        for (int i = 0; i < 4; i++) begin
            wr = 1'b1; tx_data = 8'(i);
            tick();
        end
        wr = 1'b0;
        repeat (8) tick();
        checks++; if (level !== 5'd3 || tx !== 1'b0) begin errors++; $display("FAIL mid_pre: level=%0d tx=%b expected level=3 tx=0", level, tx); end
        resetq = 1'b0;
        #1;
        checks++; if (tx !== 1'b1 || level !== 5'd0 || busy !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("FAIL mid_reset: tx=%b level=%0d busy=%b empty=%b expected 1 0 0 1", tx, level, busy, empty);
        end
        tick();
        resetq = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) saw = 1'b1;
            tick();
        end
        checks++; if (saw) begin errors++; $display("FAIL mid_silent: activity seen after reset, expected none"); end
        wr = 1'b1; tx_data = 8'hA5;
        tick();
        wr = 1'b0;
        rx_byte(b, sb, found);
        checks++; if (!found || b !== 8'hA5 || sb !== 1'b1) begin errors++; $display("FAIL mid_new_byte: got %h stop=%b expected a5 stop=1", b, sb); end
        wait_idle();
    endtask

    task automatic test_loopback();
        logic [7:0] msg [3];
        logic [7:0] got [3];
        logic       sb [3];
        logic       fnd [3];
        msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = 8'h0A;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    wr = 1'b1; tx_data = msg[i];
                    tick();
                end
                wr = 1'b0;
            end
            begin
                for (int i = 0; i < 3; i++) rx_byte(got[i], sb[i], fnd[i]);
            end
        join
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (!fnd[i] || got[i] !== msg[i] || sb[i] !== 1'b1) begin
                errors++; $display("FAIL loopback %0d: got %h stop=%b expected %h stop=1", i, got[i], sb[i], msg[i]);
            end
        end
        wait_idle();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_late_write();
        test_overflow();
        test_reset_mid();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
